// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the load
// buffer and ROB store commit. It tracks the one outstanding load tag, returns
// load results with their ROB tag, and drops results of squashed loads.
// A store that keeps winning while a load waits is overtaken once the streak
// reaches STARVE_LIMIT.
// Optional feature macro: DMEM_ARB_PERF_EN adds 32-bit accepted-load,
// accepted-store and rejected-command counters.
module dmem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int ROB_TAG_LEN  = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   squash_i,
  input  logic                   lb_read_mem_i,
  input  logic [XLEN-1:0]        lb_address_i,
  input  logic [ROB_TAG_LEN-1:0] lb_rob_tag_i,
  input  logic [1:0]             lb_size_i,
  output logic                   load_stall_o,
  input  logic                   st_req_i,
  input  logic [XLEN-1:0]        st_address_i,
  input  logic [XLEN-1:0]        st_data_i,
  input  logic [1:0]             st_size_i,
  output logic                   st_ack_o,
  output logic [1:0]             proc2mem_command_o,
  output logic [XLEN-1:0]        proc2mem_addr_o,
  output logic [63:0]            proc2mem_data_o,
  output logic [1:0]             proc2mem_size_o,
  input  logic [3:0]             mem2proc_response_i,
  input  logic [63:0]            mem2proc_data_i,
  input  logic [3:0]             mem2proc_tag_i,
  output logic                   ld_done_valid_o,
  output logic [XLEN-1:0]        ld_done_data_o,
  output logic [ROB_TAG_LEN-1:0] ld_done_rob_tag_o
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]            perf_load_cnt_o,
  output logic [31:0]            perf_store_cnt_o,
  output logic [31:0]            perf_reject_cnt_o
`endif
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, LOAD_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             tag_q, tag_d;
  logic [ROB_TAG_LEN-1:0] rob_q, rob_d;
  logic                   hi_q, hi_d;
  logic [CNT_W-1:0]       starve_q, starve_d;
  logic                   done_valid_q, done_valid_d;
  logic [XLEN-1:0]        done_data_q, done_data_d;
  logic [ROB_TAG_LEN-1:0] done_rob_q, done_rob_d;

  logic load_elig, grant_load, grant_store, mem_accept, load_accept, tag_match;

  // Arbitration: loads only start from IDLE outside a squash; the store wins
  // ties until the starvation streak hits its limit. Nothing is granted in reset.
  assign load_elig   = lb_read_mem_i && (state_q == IDLE) && !squash_i;
  assign grant_load  = !reset_i && load_elig && (!st_req_i || (starve_q == STARVE_MAX));
  assign grant_store = !reset_i && st_req_i && !grant_load;
  assign mem_accept  = |mem2proc_response_i;
  assign load_accept = grant_load && mem_accept;
  assign tag_match   = (|mem2proc_tag_i) && (mem2proc_tag_i == tag_q);

  assign st_ack_o          = grant_store && mem_accept;
  assign load_stall_o      = lb_read_mem_i && !load_accept;
  assign ld_done_valid_o   = done_valid_q;
  assign ld_done_data_o    = done_data_q;
  assign ld_done_rob_tag_o = done_rob_q;

  // Command mux: drive the bus with whichever requester holds the grant.
  always_comb begin
    proc2mem_command_o = BUS_NONE;
    proc2mem_addr_o    = '0;
    proc2mem_data_o    = '0;
    proc2mem_size_o    = 2'd0;
    if (grant_load) begin
      proc2mem_command_o = BUS_LOAD;
      proc2mem_addr_o    = lb_address_i;
      proc2mem_size_o    = lb_size_i;
    end else if (grant_store) begin
      proc2mem_command_o = BUS_STORE;
      proc2mem_addr_o    = st_address_i;
      proc2mem_data_o    = 64'({st_data_i, st_data_i});
      proc2mem_size_o    = st_size_i;
    end
  end

  // Next-state logic: load tracking FSM, result capture and starvation streak.
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    rob_d        = rob_q;
    hi_d         = hi_q;
    starve_d     = starve_q;
    done_valid_d = 1'b0;
    done_data_d  = done_data_q;
    done_rob_d   = done_rob_q;

    case (state_q)
      IDLE: begin
        if (load_accept) begin
          tag_d   = mem2proc_response_i;
          rob_d   = lb_rob_tag_i;
          hi_d    = lb_address_i[2];
          state_d = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        if (tag_match) begin
          state_d = IDLE;
          // A squash landing on the match cycle kills the result.
          if (!squash_i) begin
            done_valid_d = 1'b1;
            done_data_d  = hi_q ? XLEN'(mem2proc_data_i[63:32]) : XLEN'(mem2proc_data_i[31:0]);
            done_rob_d   = rob_q;
          end
        end else if (squash_i) begin
          state_d = LOAD_DRAIN;
        end
      end
      LOAD_DRAIN: begin
        if (tag_match) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The streak only counts stores that jumped ahead of a load able to go.
    if (!lb_read_mem_i || load_accept) begin
      starve_d = '0;
    end else if (st_ack_o && load_elig && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // State and result registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      rob_q        <= '0;
      hi_q         <= 1'b0;
      starve_q     <= '0;
      done_valid_q <= 1'b0;
      done_data_q  <= '0;
      done_rob_q   <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      rob_q        <= rob_d;
      hi_q         <= hi_d;
      starve_q     <= starve_d;
      done_valid_q <= done_valid_d;
      done_data_q  <= done_data_d;
      done_rob_q   <= done_rob_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_load_q, perf_store_q, perf_reject_q;

  assign perf_load_cnt_o   = perf_load_q;
  assign perf_store_cnt_o  = perf_store_q;
  assign perf_reject_cnt_o = perf_reject_q;

  // Free-running event counters; they wrap on overflow.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      perf_load_q   <= '0;
      perf_store_q  <= '0;
      perf_reject_q <= '0;
    end else begin
      if (load_accept) perf_load_q <= perf_load_q + 32'd1;
      if (st_ack_o)    perf_store_q <= perf_store_q + 32'd1;
      if ((proc2mem_command_o != BUS_NONE) && !mem_accept)
        perf_reject_q <= perf_reject_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the memory port.
module tb_dmem_port_arbiter;
  localparam int XLEN = 32;
  localparam int RTL  = 5;
  localparam int LIM  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            squash;
  logic            lb_read_mem;
  logic [XLEN-1:0] lb_address;
  logic [RTL-1:0]  lb_rob_tag;
  logic [1:0]      lb_size;
  logic            load_stall;
  logic            st_req;
  logic [XLEN-1:0] st_address;
  logic [XLEN-1:0] st_data;
  logic [1:0]      st_size;
  logic            st_ack;
  logic [1:0]      cmd;
  logic [XLEN-1:0] mem_addr;
  logic [63:0]     mem_wdata;
  logic [1:0]      mem_size;
  logic [3:0]      resp;
  logic [63:0]     mdata;
  logic [3:0]      mtag;
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic [RTL-1:0]  ld_rob;

  dmem_port_arbiter #(.XLEN(XLEN), .ROB_TAG_LEN(RTL), .STARVE_LIMIT(LIM)) dut (
    .clock_i(clk), .reset_i(rst), .squash_i(squash),
    .lb_read_mem_i(lb_read_mem), .lb_address_i(lb_address), .lb_rob_tag_i(lb_rob_tag),
    .lb_size_i(lb_size), .load_stall_o(load_stall),
    .st_req_i(st_req), .st_address_i(st_address), .st_data_i(st_data), .st_size_i(st_size),
    .st_ack_o(st_ack),
    .proc2mem_command_o(cmd), .proc2mem_addr_o(mem_addr), .proc2mem_data_o(mem_wdata),
    .proc2mem_size_o(mem_size),
    .mem2proc_response_i(resp), .mem2proc_data_i(mdata), .mem2proc_tag_i(mtag),
    .ld_done_valid_o(ld_valid), .ld_done_data_o(ld_data), .ld_done_rob_tag_o(ld_rob)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model of the port: one load may be in flight; a squash dooms it.
  bit             m_busy, m_doomed, m_hi, m_pulse;
  logic [3:0]     m_tag;
  logic [RTL-1:0] m_rob, m_prob;
  logic [31:0]    m_data;
  int             m_streak;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_doomed = 0; m_hi = 0; m_pulse = 0;
    m_tag = '0; m_rob = '0; m_prob = '0; m_data = '0; m_streak = 0;
  endtask

  task automatic idle_in();
    squash = 0; lb_read_mem = 0; lb_address = '0; lb_rob_tag = '0; lb_size = 2'd0;
    st_req = 0; st_address = '0; st_data = '0; st_size = 2'd0;
    resp = 4'd0; mdata = '0; mtag = 4'd0;
  endtask

  // One clock cycle: check the combinational port decisions, clock, then
  // check the registered result against the model.
  task automatic step();
    bit load_can, load_wins, store_wins, accept;
    #1;
    load_can   = lb_read_mem && !m_busy && !squash;
    load_wins  = !rst && load_can && (!st_req || m_streak == LIM);
    store_wins = !rst && st_req && !load_wins;
    accept     = (resp != 4'd0);
    chk("command", 64'(cmd), load_wins ? 64'd1 : (store_wins ? 64'd2 : 64'd0));
    chk("st_ack", 64'(st_ack), 64'(store_wins && accept));
    chk("load_stall", 64'(load_stall), 64'(lb_read_mem && !(load_wins && accept)));
    if (load_wins) begin
      chk("ld_addr", 64'(mem_addr), 64'(lb_address));
      chk("ld_size", 64'(mem_size), 64'(lb_size));
    end
    if (store_wins) begin
      chk("st_addr", 64'(mem_addr), 64'(st_address));
      chk("st_wdata", mem_wdata, {st_data, st_data});
      chk("st_size", 64'(mem_size), 64'(st_size));
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_pulse = 0;
      if (m_busy) begin
        if (mtag != 4'd0 && mtag == m_tag) begin
          m_busy = 0;
          if (!m_doomed && !squash) begin
            m_pulse = 1;
            m_data  = m_hi ? mdata[63:32] : mdata[31:0];
            m_prob  = m_rob;
          end
          m_doomed = 0;
        end else if (squash) begin
          m_doomed = 1;
        end
      end else if (load_wins && accept) begin
        m_busy = 1; m_doomed = 0; m_tag = resp; m_rob = lb_rob_tag; m_hi = lb_address[2];
      end
      if (!lb_read_mem || (load_wins && accept)) m_streak = 0;
      else if (store_wins && accept && load_can && m_streak < LIM) m_streak++;
    end
    #1;
    chk("ld_done_valid", 64'(ld_valid), 64'(m_pulse));
    if (m_pulse) begin
      chk("ld_done_data", 64'(ld_data), 64'(m_data));
      chk("ld_done_rob", 64'(ld_rob), 64'(m_prob));
    end
    @(negedge clk);
  endtask

  // Reset pulse that lands and releases between clock edges.
  task automatic async_reset_pulse();
    rst = 1;
    #1;
    model_reset();
    chk("rst_cmd", 64'(cmd), 64'd0);
    chk("rst_st_ack", 64'(st_ack), 64'd0);
    chk("rst_ld_valid", 64'(ld_valid), 64'd0);
    chk("rst_load_stall", 64'(load_stall), 64'(lb_read_mem));
    #1;
    rst = 0;
  endtask

  initial begin
    int acks, load_at;
    logic [3:0] t;
    rst = 1;
    idle_in();
    model_reset();
    step();
    lb_read_mem = 1; st_req = 1; resp = 4'd2;
    step();
    chk("reset_ld_valid", 64'(ld_valid), 64'd0);
    rst = 0;

    // 1: load from 0x104 returns the upper word with its ROB tag.
    idle_in(); lb_read_mem = 1; lb_address = 32'h104; lb_rob_tag = 5'd5; lb_size = 2'd2; resp = 4'd3;
    step();
    idle_in(); step();
    mtag = 4'd3; mdata = 64'hDEADBEEF_12345678; step();
    chk("t1_pulse", 64'(ld_valid), 64'd1);
    chk("t1_data", 64'(ld_data), 64'hDEADBEEF);
    chk("t1_rob", 64'(ld_rob), 64'd5);
    idle_in(); step();
    chk("t1_one_cycle", 64'(ld_valid), 64'd0);

    // 2: continuous contention: four stores, then the load is forced ahead.
    idle_in(); lb_read_mem = 1; lb_address = 32'h200; lb_rob_tag = 5'd1;
    st_req = 1; st_address = 32'h300; st_data = 32'hA5A5_0001; st_size = 2'd2; resp = 4'd1;
    acks = 0; load_at = -1;
    for (int i = 0; i < 5; i++) begin
      #1;
      acks += int'(st_ack);
      if (!load_stall && load_at < 0) load_at = i;
      step();
    end
    chk("t2_store_acks", 64'(acks), 64'd4);
    chk("t2_load_cycle", 64'(load_at), 64'd4);
    lb_read_mem = 0; mtag = 4'd1; step();
    mtag = 4'd0; lb_read_mem = 1; step();   // streak back to 0: store wins again
    lb_read_mem = 0; st_req = 0; step();

    // 3: rejected store is held and retried until accepted.
    idle_in(); st_req = 1; st_address = 32'h44; st_data = 32'h1234_5678; st_size = 2'd1;
    for (int i = 0; i < 3; i++) step();
    resp = 4'd2;
    #1 chk("t3_ack", 64'(st_ack), 64'd1);
    step();

    // 4: squash after accept drains the load silently.
    idle_in(); lb_read_mem = 1; lb_address = 32'h8; lb_rob_tag = 5'd9; resp = 4'd7; step();
    resp = 4'd0; squash = 1; step();
    squash = 0; step(); step();
    mtag = 4'd7; mdata = 64'h1111_2222_3333_4444; step();
    chk("t4_no_pulse", 64'(ld_valid), 64'd0);
    mtag = 4'd0; resp = 4'd4;
    #1 chk("t4_reissue", 64'(load_stall), 64'd0);
    step();
    idle_in(); mtag = 4'd4; mdata = 64'h5555_6666_7777_8888; step();

    // 5: squash on the match cycle suppresses the pulse and returns to IDLE.
    idle_in(); lb_read_mem = 1; lb_address = 32'h10; lb_rob_tag = 5'd3; resp = 4'd9; step();
    idle_in(); mtag = 4'd9; squash = 1; mdata = 64'hCAFE_F00D_0BAD_BEEF; step();
    chk("t5_no_pulse", 64'(ld_valid), 64'd0);
    idle_in(); lb_read_mem = 1; lb_rob_tag = 5'd4; resp = 4'd5; step();
    idle_in(); mtag = 4'd5; step();

    // 6: async reset in LOAD_WAIT; the old tag is ignored afterwards.
    idle_in(); lb_read_mem = 1; lb_address = 32'h20; lb_rob_tag = 5'd12; resp = 4'd6; step();
    idle_in(); lb_read_mem = 1; st_req = 1; resp = 4'd3;
    async_reset_pulse();
    st_req = 0;
    step();                                   // IDLE again: load accepted, tag 3
    idle_in(); mtag = 4'd6; step();
    chk("t6_stale_tag", 64'(ld_valid), 64'd0);
    mtag = 4'd3; mdata = 64'h0F0F_0F0F_F0F0_F0F0; step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      lb_read_mem = ($urandom_range(0, 3) != 0);
      lb_address  = $urandom;
      lb_rob_tag  = RTL'($urandom_range(0, 31));
      lb_size     = 2'($urandom_range(0, 3));
      st_req      = ($urandom_range(0, 2) == 0);
      st_address  = $urandom;
      st_data     = $urandom;
      st_size     = 2'($urandom_range(0, 3));
      resp        = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      squash      = ($urandom_range(0, 15) == 0);
      mdata       = {$urandom, $urandom};
      if (m_busy && $urandom_range(0, 3) == 0) begin
        mtag = m_tag;
      end else begin
        t = 4'($urandom_range(0, 15));
        if (m_busy && t == m_tag) t = 4'd0;
        mtag = t;
      end
      if (i == 200) async_reset_pulse();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
